// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and baud-oversampling defaults.
// Also imported by the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int MID_TICK_DEF   = 7;

endpackage

// File: rtl/uart_receiver_rx_sync.sv
// Two-flop synchronizer for the serial line; flops reset to the idle (high) level.
module rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic synced
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b1;
         synced <= 1'b1;
      end else begin
         meta   <= line;
         synced <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver clocked by a 16x baud tick clock.
// Samples mid-bit, flags framing errors and waits out a line break.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int MID_TICK   = MID_TICK_DEF
) (
   input  logic       br_clk_16,
   input  logic       reset,
   input  logic       UART_RX,
   output logic [7:0] RX_DATA,
   output logic       RX_STATUS,
   output logic       FRAME_ERR,
   output logic       RX_BUSY
);

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID       = 4'(MID_TICK);

   rx_state_t  state, state_nx;
   logic [3:0] tick, tick_nx;
   logic [2:0] bit_cnt, bit_nx;
   logic [7:0] shift, shift_nx;
   logic [7:0] data_nx;
   logic       status_nx, ferr_nx;
   logic       rxs;

   rx_sync u_sync (
      .clk    (br_clk_16),
      .rst_n  (reset),
      .line   (UART_RX),
      .synced (rxs)
   );

   always_ff @(posedge br_clk_16 or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tick      <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         RX_DATA   <= '0;
         RX_STATUS <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         state     <= state_nx;
         tick      <= tick_nx;
         bit_cnt   <= bit_nx;
         shift     <= shift_nx;
         RX_DATA   <= data_nx;
         RX_STATUS <= status_nx;
         FRAME_ERR <= ferr_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      tick_nx   = tick;
      bit_nx    = bit_cnt;
      shift_nx  = shift;
      data_nx   = RX_DATA;
      status_nx = 1'b0;
      ferr_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rxs) begin
               state_nx = START;
               tick_nx  = '0;
            end
         end
         START: begin
            if (tick == MID) begin
               tick_nx  = '0;
               state_nx = rxs ? IDLE : DATA;
            end else begin
               tick_nx = tick + 4'd1;
            end
         end
         DATA: begin
            if (tick == LAST_TICK) begin
               tick_nx  = '0;
               shift_nx = {rxs, shift[7:1]};
               bit_nx   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nx = STOP;
                  bit_nx   = '0;
               end
            end else begin
               tick_nx = tick + 4'd1;
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit leaves room for a back-to-back start edge.
            if (tick == LAST_TICK) begin
               tick_nx = '0;
               if (rxs) begin
                  data_nx   = shift;
                  status_nx = 1'b1;
                  state_nx  = IDLE;
               end else begin
                  ferr_nx  = 1'b1;
                  state_nx = BREAK;
               end
            end else begin
               tick_nx = tick + 4'd1;
            end
         end
         BREAK: begin
            if (rxs) state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            tick_nx  = '0;
            bit_nx   = '0;
         end
      endcase
   end

   assign RX_BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected frames,
// a monitor pops them on every RX_STATUS / FRAME_ERR pulse.
module tb_uart_receiver;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       br_clk_16;
   logic       reset;
   logic       UART_RX;
   logic [7:0] RX_DATA;
   logic       RX_STATUS;
   logic       FRAME_ERR;
   logic       RX_BUSY;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic [7:0] model_data = 8'h00;
   logic       prev_pulse = 1'b0;

   uart_receiver dut (
      .br_clk_16 (br_clk_16),
      .reset     (reset),
      .UART_RX   (UART_RX),
      .RX_DATA   (RX_DATA),
      .RX_STATUS (RX_STATUS),
      .FRAME_ERR (FRAME_ERR),
      .RX_BUSY   (RX_BUSY)
   );

   initial br_clk_16 = 1'b0;
   always #5 br_clk_16 = ~br_clk_16;

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge br_clk_16);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      sb.push_back('{1'b0, b});
      for (int i = 0; i < 10; i++) begin
         UART_RX = fr[i];
         if (i >= 1 && i <= 8) begin
            ticks(4);
            check("busy_in_frame", {7'd0, RX_BUSY}, 8'd1);
            ticks(12);
         end else begin
            ticks(16);
         end
      end
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   always @(negedge br_clk_16) begin
      if (!reset) begin
         model_data = 8'h00;
         prev_pulse = 1'b0;
      end else begin
         if (RX_STATUS || FRAME_ERR) begin
            check("pulse_exclusive", {7'd0, RX_STATUS & FRAME_ERR}, 8'd0);
            check("pulse_one_cycle", {7'd0, prev_pulse}, 8'd0);
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse: status=%0b ferr=%0b data=%0h",
                        RX_STATUS, FRAME_ERR, RX_DATA);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("pulse_kind_ferr", {7'd0, FRAME_ERR}, {7'd0, e.err});
               if (!e.err) model_data = e.data;
               check("rx_data", RX_DATA, model_data);
            end
         end
         prev_pulse = RX_STATUS | FRAME_ERR;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      UART_RX = 1'b1;
      reset   = 1'b0;
      ticks(3);
      check("reset_data", RX_DATA, 8'h00);
      check("reset_status", {7'd0, RX_STATUS}, 8'd0);
      check("reset_ferr", {7'd0, FRAME_ERR}, 8'd0);
      check("reset_busy", {7'd0, RX_BUSY}, 8'd0);
      reset = 1'b1;
      ticks(20);

      send_byte(8'h55);
      ticks(20);
      check("idle_after_55", {7'd0, RX_BUSY}, 8'd0);

      send_byte(8'hA5);
      send_byte(8'h3C);
      ticks(20);

      // Short low glitch: must fall back to IDLE silently.
      UART_RX = 1'b0;
      ticks(4);
      UART_RX = 1'b1;
      ticks(24);
      check("glitch_idle", {7'd0, RX_BUSY}, 8'd0);
      check("glitch_data", RX_DATA, 8'h3C);

      // 0xFF with the stop bit held low for 3 bit periods.
      sb.push_back('{1'b1, 8'h00});
      UART_RX = 1'b0;
      ticks(16);
      UART_RX = 1'b1;
      ticks(128);
      UART_RX = 1'b0;
      ticks(48);
      check("break_hold", {7'd0, RX_BUSY}, 8'd1);
      UART_RX = 1'b1;
      ticks(20);
      check("break_exit", {7'd0, RX_BUSY}, 8'd0);
      check("break_data", RX_DATA, 8'h3C);
      send_byte(8'h00);
      ticks(20);

      // Reset during data bit 4 of 0x81.
      UART_RX = 1'b0;
      ticks(16);
      UART_RX = 1'b1;
      ticks(16);
      UART_RX = 1'b0;
      ticks(56);
      reset = 1'b0;
      ticks(2);
      check("mid_reset_data", RX_DATA, 8'h00);
      check("mid_reset_status", {7'd0, RX_STATUS}, 8'd0);
      check("mid_reset_ferr", {7'd0, FRAME_ERR}, 8'd0);
      check("mid_reset_busy", {7'd0, RX_BUSY}, 8'd0);
      UART_RX = 1'b1;
      ticks(4);
      reset = 1'b1;
      ticks(32);
      check("post_reset_idle", {7'd0, RX_BUSY}, 8'd0);
      send_byte(8'h81);
      ticks(20);

      send_byte(8'h00);
      ticks(16);
      check("gap_busy", {7'd0, RX_BUSY}, 8'd0);
      send_byte(8'hFF);

      for (int i = 0; i < 400 && sb.size() != 0; i++) ticks(1);
      check("scoreboard_empty", 8'(sb.size()), 8'd0);
      check("final_data", RX_DATA, 8'hFF);
      check("final_idle", {7'd0, RX_BUSY}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, the number of br_clk_16 ticks per bit period.
REQ-002 The block SHALL have parameter MID_TICK, default 7, the tick index used to sample the centre of the start bit.
REQ-003 The block SHALL have port br_clk_16  input  1  16x baud clock; the only clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port UART_RX  input  1  serial line; idles high; asynchronous to br_clk_16.
REQ-006 The block SHALL have port RX_DATA  output  8  last correctly framed byte.
REQ-007 The block SHALL have port RX_STATUS  output  1  one-cycle pulse: RX_DATA has just been updated.
REQ-008 The block SHALL have port FRAME_ERR  output  1  one-cycle pulse: the stop bit was sampled low.
REQ-009 The block SHALL have port RX_BUSY  output  1  high in every state except IDLE.

Function
REQ-010 UART_RX SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions SHALL use the synchronized value rxs.
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with no parity.
REQ-012 The state machine SHALL have the states IDLE, START, DATA, STOP and BREAK; the tick counter SHALL be 4 bits and the bit counter 3 bits.
REQ-013 IDLE: when rxs==0 the machine SHALL move to START with the tick counter at 0; otherwise it SHALL stay in IDLE.
REQ-014 START: the tick counter SHALL increment each tick; at tick==MID_TICK, rxs==0 SHALL move to DATA, and rxs==1 SHALL be treated as a glitch and return to IDLE; in both cases the tick counter SHALL clear.
REQ-015 DATA: at tick==OVERSAMPLE-1, rxs SHALL be shifted into bit[7] of the shift register (right shift), the tick counter SHALL clear, and the bit counter SHALL increment; after the 8th sample the machine SHALL move to STOP.
REQ-016 STOP: at tick==OVERSAMPLE-1 with rxs==1, the block SHALL load RX_DATA from the shift register, pulse RX_STATUS, and go to IDLE.
REQ-017 STOP: at tick==OVERSAMPLE-1 with rxs==0, the block SHALL pulse FRAME_ERR, leave RX_DATA unchanged, and go to BREAK.
REQ-018 BREAK: the machine SHALL stay in BREAK until rxs==1, then go to IDLE; a low line SHALL NOT start a new frame from BREAK.
REQ-019 RX_STATUS and FRAME_ERR SHALL be registered, SHALL be high for exactly one br_clk_16 cycle, and SHALL never both be high in the same cycle.
REQ-020 RX_DATA SHALL hold its value until the next valid frame completes, with no acknowledge required; an unread byte SHALL be overwritten silently.
REQ-021 Back-to-back frames SHALL be received: the return to IDLE at mid-stop-bit allows a start edge within 8 ticks of that point.
REQ-022 Latency SHALL be 2 cycles from a UART_RX edge to rxs, and RX_STATUS SHALL rise in the cycle after the stop-bit sample edge.
REQ-023 The counters SHALL never wrap within a state; each counter SHALL clear on every state change.

Reset
REQ-024 While reset==0, the block SHALL hold: state=IDLE, counters=0, shift register=0, RX_DATA=8'h00, RX_STATUS=0, FRAME_ERR=0, RX_BUSY=0, and synchronizer flops=1.
REQ-025 A reset asserted mid-frame SHALL discard the partial byte and SHALL raise no pulse; after release the block SHALL wait in IDLE for a fresh falling edge.

Structure
REQ-026 The state encodings and the defaults for OVERSAMPLE and MID_TICK SHALL reside in the shared UART package, which is also used by the transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module named rx_sync (2 flops, reset value 1); all other logic SHALL reside in uart_receiver.

Verification
REQ-028 Scenario: send 0x55 framed at 16 ticks/bit -> RX_DATA==8'h55, one RX_STATUS pulse, FRAME_ERR never high.
REQ-029 Scenario: send 0xA5 then 0x3C with zero idle between frames -> two RX_STATUS pulses; RX_DATA==8'hA5, then 8'h3C.
REQ-030 Scenario: drive UART_RX low for 4 ticks, then high -> return to IDLE with no pulse, and RX_DATA unchanged.
REQ-031 Scenario: send 0xFF with the stop bit driven low for 3 bit periods -> one FRAME_ERR pulse, RX_DATA unchanged, BREAK held until the line goes high, then 0x00 received correctly.
REQ-032 Scenario: assert reset during data bit 4 of 0x81 -> all outputs at reset values, no pulse; the following 0x81 is received as 8'h81.
REQ-033 Scenario: send 0x00, then 0xFF -> RX_DATA values are correct, and RX_BUSY is low only between frames.
